// File: rtl/write_ctrl_pkg.sv
// Shared types and constants for the SDRAM write master controller.
package write_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUF,
    WRITE,
    GROUP_END,
    DONE
  } wr_state_t;

  localparam int         PIXEL_W    = 24;
  localparam int         BUS_W      = 32;
  localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/flex_counter.sv
// Counts 0..rollover_val-1 on count_enable, then wraps to 0; clear has priority over enable.
module flex_counter #(
  parameter int NUM_BITS = 3
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS:0]   rollover_val,
  output logic [NUM_BITS-1:0] count_out
);

  logic [NUM_BITS:0] next_val;

  // One extra bit so a rollover value of 2^NUM_BITS is still representable.
  assign next_val = {1'b0, count_out} + {{NUM_BITS{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (next_val == rollover_val) count_out <= '0;
      else                          count_out <= next_val[NUM_BITS-1:0];
    end
  end

endmodule

// File: rtl/write_master_controller.sv
// Drains complete pixel groups from the ping-pong write buffer into single-word
// Avalon-MM writes at incrementing addresses, counting pixels up to a full frame.
module write_master_controller
  import write_ctrl_pkg::*;
#(
  parameter int GROUP_SIZE   = 6,
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_STEP    = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [BUS_W-1:0]   base_addr,
  input  logic               abort,
  input  logic               buf_ready,
  input  logic [PIXEL_W-1:0] buf_data,
  output logic               buf_pop,
  output logic [BUS_W-1:0]   master_address,
  output logic               master_write,
  output logic [BUS_W-1:0]   master_writedata,
  output logic [3:0]         master_byteenable,
  input  logic               master_waitrequest,
  output logic               group_done,
  output logic               frame_done,
  output logic               busy,
  output wr_state_t          dbg_state
);

  localparam int               WC_W      = $clog2(GROUP_SIZE);
  localparam int               PC_W      = $clog2(FRAME_PIXELS + 1);
  localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(GROUP_SIZE - 1);
  localparam logic [PC_W-1:0]  FRAME_END = PC_W'(FRAME_PIXELS);
  localparam logic [BUS_W-1:0] STEP      = BUS_W'(ADDR_STEP);

  // Handshake: a write is presented while master_write=1 and is accepted on any
  // such cycle with master_waitrequest=0; address and data stay put until then,
  // and buf_pop pulses in that same accepting cycle.

  wr_state_t        state;
  logic [BUS_W-1:0] addr;
  logic [PC_W-1:0]  pix_cnt;
  logic [WC_W-1:0]  word_cnt;
  logic             abort_pend;
  logic             accept;
  logic             cnt_clear;
  logic             last_word;

  assign accept    = (state == WRITE) && !master_waitrequest;
  assign cnt_clear = (state == WAIT_BUF) && buf_ready && !abort;
  assign last_word = (word_cnt == WORD_LAST);

  flex_counter #(
    .NUM_BITS(WC_W)
  ) u_word_cnt (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (cnt_clear),
    .count_enable(accept),
    .rollover_val((WC_W + 1)'(GROUP_SIZE)),
    .count_out   (word_cnt)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      addr       <= '0;
      pix_cnt    <= '0;
      abort_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            addr    <= base_addr;
            pix_cnt <= '0;
            state   <= WAIT_BUF;
          end
        end
        WAIT_BUF: begin
          if (abort)          state <= IDLE;
          else if (buf_ready) state <= WRITE;
        end
        WRITE: begin
          // A stalled request cannot be withdrawn, so an abort is remembered
          // until the pending word is accepted.
          if (accept) begin
            addr       <= addr + STEP;
            pix_cnt    <= pix_cnt + PC_W'(1);
            abort_pend <= 1'b0;
            if (abort || abort_pend) state <= IDLE;
            else if (last_word)      state <= GROUP_END;
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
        GROUP_END: begin
          if (abort)                     state <= IDLE;
          else if (pix_cnt == FRAME_END) state <= DONE;
          else                           state <= WAIT_BUF;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign master_write      = (state == WRITE);
  assign master_address    = addr;
  assign master_writedata  = master_write ? {{(BUS_W - PIXEL_W){1'b0}}, buf_data} : '0;
  assign master_byteenable = master_write ? BYTEEN_ALL : 4'b0000;
  assign buf_pop           = accept;
  assign group_done        = (state == GROUP_END) && !abort;
  assign frame_done        = (state == DONE) && !abort;
  assign busy              = (state != IDLE);
  assign dbg_state         = state;

endmodule
